// File: rtl/fpu_pkg.sv
// Shared FP definitions: op-code encodings, register-number width and the
// shadow-pipeline stage record used by the issue scoreboard.
package fpu_pkg;

    localparam int FREG_W = 5;
    localparam int CNT_W  = 5;

    typedef enum logic [2:0] {
        FC_ADD  = 3'b000,
        FC_SUB  = 3'b001,
        FC_MUL  = 3'b010,
        FC_DIV  = 3'b011,
        FC_SQRT = 3'b100
    } fc_e;

    // One shadow-pipeline stage: destination register and its write enable.
    typedef struct packed {
        logic [FREG_W-1:0] n;
        logic              w;
    } stage_t;

endpackage

// File: rtl/fp_ds_counter.sv
// Loadable down-counter for div/sqrt E1 occupancy. Loads CYCLES-1 on issue,
// counts down to zero and stops there; busy is high while nonzero.
module fp_ds_counter
    import fpu_pkg::*;
#(
    parameter int CYCLES = 24
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load on issue, otherwise decrement and saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = (cnt_q != '0);

endmodule

// File: rtl/fp_issue_scoreboard.sv
// IU-side FP issue interlock: shadow E1/E2/E3 destination pipeline, RAW
// hazard detection on fs/ft, E3 forwarding selects, and div/sqrt freeze.
// Optional stall counter output enabled by defining FPSB_PERF_EN.
//
// Handshake: id_fop is the valid from ID; the op is accepted (e=1) in any
// cycle where id_fop=1 and stall=0. While stall=1 ID must hold its op.
module fp_issue_scoreboard
    import fpu_pkg::*;
#(
    parameter int DIV_CYCLES  = 24,
    parameter int SQRT_CYCLES = 24
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              id_fop,
    input  logic [2:0]        id_fc,
    input  logic [FREG_W-1:0] id_fd,
    input  logic              id_wf,
    input  logic [FREG_W-1:0] id_fs,
    input  logic [FREG_W-1:0] id_ft,
    input  logic              id_use_fs,
    input  logic              id_use_ft,
    output logic              stall,
    output logic              e,
    output logic              fwdfa,
    output logic              fwdfb,
    output logic [FREG_W-1:0] e1n,
    output logic [FREG_W-1:0] e2n,
    output logic [FREG_W-1:0] e3n,
    output logic              e1w,
    output logic              e2w,
    output logic              e3w,
    output logic              st_ds,
`ifdef FPSB_PERF_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [CNT_W-1:0]  cnt_div,
    output logic [CNT_W-1:0]  cnt_sqrt
);

    stage_t e1_q, e1_d;
    stage_t e2_q, e2_d;
    stage_t e3_q, e3_d;

    logic haz_a;
    logic haz_b;
    logic div_busy;
    logic sqrt_busy;
    logic div_load;
    logic sqrt_load;

    // Hazard, forwarding and issue decisions from the current stage registers.
    always_comb begin
        haz_a = id_use_fs & ((e1_q.w & (e1_q.n == id_fs)) | (e2_q.w & (e2_q.n == id_fs)));
        haz_b = id_use_ft & ((e1_q.w & (e1_q.n == id_ft)) | (e2_q.w & (e2_q.n == id_ft)));
        fwdfa = id_use_fs & e3_q.w & (e3_q.n == id_fs) & ~haz_a;
        fwdfb = id_use_ft & e3_q.w & (e3_q.n == id_ft) & ~haz_b;
        st_ds = div_busy | sqrt_busy;
        stall = id_fop & (haz_a | haz_b | st_ds);
        e     = id_fop & ~stall;
        div_load  = e & (id_fc == FC_DIV);
        sqrt_load = e & (id_fc == FC_SQRT);
    end

    // Stage advance; the whole shadow pipeline freezes during div/sqrt.
    always_comb begin
        e1_d = e1_q;
        e2_d = e2_q;
        e3_d = e3_q;
        if (!st_ds) begin
            e1_d.n = id_fd;
            e1_d.w = id_wf & e;
            e2_d   = e1_q;
            e3_d   = e2_q;
        end
    end

    // Stage registers, flushed asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            e1_q <= '0;
            e2_q <= '0;
            e3_q <= '0;
        end else begin
            e1_q <= e1_d;
            e2_q <= e2_d;
            e3_q <= e3_d;
        end
    end

    fp_ds_counter #(.CYCLES(DIV_CYCLES)) u_div_cnt (
        .clk  (clk),
        .clr  (clr),
        .load (div_load),
        .cnt  (cnt_div),
        .busy (div_busy)
    );

    fp_ds_counter #(.CYCLES(SQRT_CYCLES)) u_sqrt_cnt (
        .clk  (clk),
        .clr  (clr),
        .load (sqrt_load),
        .cnt  (cnt_sqrt),
        .busy (sqrt_busy)
    );

    assign e1n = e1_q.n;
    assign e2n = e2_q.n;
    assign e3n = e3_q.n;
    assign e1w = e1_q.w;
    assign e2w = e2_q.w;
    assign e3w = e3_q.w;

`ifdef FPSB_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fp_issue_scoreboard.sv
// Bench for fp_issue_scoreboard: directed ops with expected stall/forward
// behaviour, plus an in-order queue of destinations checked as they leave E3.
// Define FPSB_PERF_EN to also exercise the stall counter.
module tb_fp_issue_scoreboard;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_SQRT = 3'b100;

    logic       clk;
    logic       clr;
    logic       id_fop;
    logic [2:0] id_fc;
    logic [4:0] id_fd;
    logic       id_wf;
    logic [4:0] id_fs;
    logic [4:0] id_ft;
    logic       id_use_fs;
    logic       id_use_ft;
    logic       stall;
    logic       e;
    logic       fwdfa;
    logic       fwdfb;
    logic [4:0] e1n, e2n, e3n;
    logic       e1w, e2w, e3w;
    logic       st_ds;
    logic [4:0] cnt_div;
    logic [4:0] cnt_sqrt;
`ifdef FPSB_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int tests_run;
    int tests_failed;
    logic [4:0] exp_q[$];

    fp_issue_scoreboard #(.DIV_CYCLES(24), .SQRT_CYCLES(24)) dut (
        .clk       (clk),
        .clr       (clr),
        .id_fop    (id_fop),
        .id_fc     (id_fc),
        .id_fd     (id_fd),
        .id_wf     (id_wf),
        .id_fs     (id_fs),
        .id_ft     (id_ft),
        .id_use_fs (id_use_fs),
        .id_use_ft (id_use_ft),
        .stall     (stall),
        .e         (e),
        .fwdfa     (fwdfa),
        .fwdfb     (fwdfb),
        .e1n       (e1n),
        .e2n       (e2n),
        .e3n       (e3n),
        .e1w       (e1w),
        .e2w       (e2w),
        .e3w       (e3w),
        .st_ds     (st_ds),
`ifdef FPSB_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .cnt_div   (cnt_div),
        .cnt_sqrt  (cnt_sqrt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Ops leave E3 (reach the register file) on any edge where the pipe is
    // not frozen; they must come out in issue order.
    always @(negedge clk) begin
        if (!clr && !st_ds && e3w) begin
            check_eq("retire_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check_eq("retire_fd", 32'(e3n), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        id_fop = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present an op, count stalled cycles until it is accepted, check the
    // forwarding selects in the accepting cycle. Returns 1 after that edge.
    task automatic drive_op(input string tag, input logic [2:0] fc, input logic [4:0] fd,
                            input logic [4:0] fs, input logic [4:0] ft,
                            input logic ufs, input logic uft, input logic wf,
                            input int exp_stall, input logic exp_fa, input logic exp_fb);
        int n;
        id_fop    = 1'b1;
        id_fc     = fc;
        id_fd     = fd;
        id_fs     = fs;
        id_ft     = ft;
        id_use_fs = ufs;
        id_use_ft = uft;
        id_wf     = wf;
        n = 0;
        @(negedge clk);
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_eq({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        check_eq({tag, "_e"}, 32'(e), 32'd1);
        check_eq({tag, "_fwdfa"}, 32'(fwdfa), 32'(exp_fa));
        check_eq({tag, "_fwdfb"}, 32'(fwdfb), 32'(exp_fb));
        if (e && wf) exp_q.push_back(fd);
        @(posedge clk);
        #1;
        id_fop = 1'b0;
    endtask

    initial begin
        int n;
        tests_run    = 0;
        tests_failed = 0;
        clr       = 1'b1;
        id_fop    = 1'b0;
        id_fc     = OP_ADD;
        id_fd     = 5'd0;
        id_wf     = 1'b0;
        id_fs     = 5'd0;
        id_ft     = 5'd0;
        id_use_fs = 1'b0;
        id_use_ft = 1'b0;

        // Reset state
        #3;
        check_eq("rst_stall", 32'(stall), 0);
        check_eq("rst_e", 32'(e), 0);
        check_eq("rst_e1w", 32'(e1w), 0);
        check_eq("rst_e3n", 32'(e3n), 0);
        check_eq("rst_st_ds", 32'(st_ds), 0);
        check_eq("rst_cnt_div", 32'(cnt_div), 0);
        check_eq("rst_cnt_sqrt", 32'(cnt_sqrt), 0);
`ifdef FPSB_PERF_EN
        check_eq("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Single add walks through E1/E2/E3
        drive_op("add3", OP_ADD, 5'd3, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        check_eq("walk_e1n", 32'(e1n), 3);
        check_eq("walk_e1w", 32'(e1w), 1);
        @(negedge clk);
        check_eq("walk_e2n", 32'(e2n), 3);
        check_eq("walk_e2w", 32'(e2w), 1);
        @(negedge clk);
        check_eq("walk_e3n", 32'(e3n), 3);
        check_eq("walk_e3w", 32'(e3w), 1);
        idle(3);

        // Back-to-back dependency: 2 stalls then forward A
        drive_op("dep_prod", OP_ADD, 5'd3, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        drive_op("dep_use", OP_MUL, 5'd5, 5'd3, 5'd2, 1, 1, 1, 2, 1, 0);
        idle(4);

        // f0 is an ordinary register; fs=ft=fd forwards both operands
        drive_op("f0_prod", OP_ADD, 5'd0, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        drive_op("f0_use", OP_SUB, 5'd6, 5'd0, 5'd0, 1, 1, 1, 2, 1, 1);
        idle(4);

        // Distance-3 dependency on ft: no stall, forward B
        drive_op("d3_prod", OP_ADD, 5'd4, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        drive_op("d3_ind1", OP_ADD, 5'd10, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        drive_op("d3_ind2", OP_ADD, 5'd11, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        drive_op("d3_use", OP_MUL, 5'd12, 5'd1, 5'd4, 1, 1, 1, 0, 0, 1);
        idle(4);

        // Source not read: no hazard even on a matching register
        drive_op("nouse_prod", OP_ADD, 5'd13, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        drive_op("nouse_use", OP_ADD, 5'd19, 5'd13, 5'd13, 0, 0, 1, 0, 0, 0);
        idle(4);

        // Hazard against E2 only: 1 stall then forward
        drive_op("e2_prod", OP_ADD, 5'd14, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        idle(1);
        drive_op("e2_use", OP_ADD, 5'd23, 5'd14, 5'd2, 1, 1, 1, 1, 1, 0);
        idle(4);

        // fdiv freezes the pipe for 23 cycles; independent op then issues
        drive_op("div", OP_DIV, 5'd8, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        id_fop = 1'b1; id_fc = OP_ADD; id_fd = 5'd9; id_fs = 5'd1; id_ft = 5'd2;
        id_use_fs = 1'b1; id_use_ft = 1'b1; id_wf = 1'b1;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            check_eq("div_cnt", 32'(cnt_div), 32'(23 - i));
            check_eq("div_st_ds", 32'(st_ds), 1);
            check_eq("div_stall", 32'(stall), 1);
            check_eq("div_e1n_hold", 32'(e1n), 8);
        end
        @(negedge clk);
        check_eq("div_end_cnt", 32'(cnt_div), 0);
        check_eq("div_end_st_ds", 32'(st_ds), 0);
        check_eq("div_end_e", 32'(e), 1);
        if (e) exp_q.push_back(5'd9);
        @(posedge clk);
        #1;
        id_fop = 1'b0;
        @(negedge clk);
        check_eq("div_e2n", 32'(e2n), 8);
        check_eq("div_e1n", 32'(e1n), 9);
        idle(4);

        // fsqrt: dependent op waits out the freeze plus two RAW cycles
        drive_op("sqrt", OP_SQRT, 5'd15, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        check_eq("sqrt_cnt_load", 32'(cnt_sqrt), 23);
        check_eq("sqrt_cnt_div_idle", 32'(cnt_div), 0);
        drive_op("sqrt_use", OP_ADD, 5'd16, 5'd15, 5'd2, 1, 0, 1, 25, 1, 0);
        idle(4);

        // Reset mid-div clears counters and flushes stages at once
        drive_op("div_clr", OP_DIV, 5'd17, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        n = 0;
        while (cnt_div != 5'd10 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("clr_reach10", 32'(cnt_div), 10);
        clr = 1'b1;
        exp_q.delete();
        #1;
        check_eq("clr_cnt_div", 32'(cnt_div), 0);
        check_eq("clr_st_ds", 32'(st_ds), 0);
        check_eq("clr_e1w", 32'(e1w), 0);
        check_eq("clr_e2w", 32'(e2w), 0);
        check_eq("clr_e3w", 32'(e3w), 0);
`ifdef FPSB_PERF_EN
        check_eq("clr_stall_cnt", 32'(stall_cnt), 0);
`endif
        @(posedge clk);
        #1;
        clr = 1'b0;
        drive_op("post_clr", OP_ADD, 5'd18, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);

        // 2 RAW stall cycles plus 23 div stall cycles since clr
        drive_op("perf_prod", OP_ADD, 5'd20, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        drive_op("perf_use", OP_ADD, 5'd24, 5'd20, 5'd2, 1, 1, 1, 2, 1, 0);
        idle(4);
        drive_op("perf_div", OP_DIV, 5'd21, 5'd1, 5'd2, 1, 1, 1, 0, 0, 0);
        drive_op("perf_ind", OP_MUL, 5'd22, 5'd1, 5'd2, 1, 1, 1, 23, 0, 0);
`ifdef FPSB_PERF_EN
        check_eq("perf_stall_cnt25", 32'(stall_cnt), 25);
`endif
        idle(6);
        check_eq("drain", 32'(exp_q.size()), 0);

`ifdef FPSB_PERF_EN
        // Continuous div issue keeps stall high long enough to saturate
        id_fop = 1'b1; id_fc = OP_DIV; id_fd = 5'd25; id_wf = 1'b0;
        id_use_fs = 1'b0; id_use_ft = 1'b0;
        repeat (3100 * 24) @(posedge clk);
        #1;
        id_fop = 1'b0;
        check_eq("perf_saturate", 32'(stall_cnt), 32'hFFFF);
        idle(30);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
